// File: rtl/cpu_job_host.sv
// Host-side job sequencer for the multicycle CPU: resets the CPU, presents an operand, captures a settled result.
// Optional RUN-phase watchdog is compiled in when HOST_TIMEOUT_EN is defined.
module cpu_job_host #(
   parameter int WIDTH          = 16,
   parameter int RESET_CYCLES   = 2,
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] operand,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             timeout,
   output logic [WIDTH-1:0] cpu_in,
   output logic             cpu_reset,
   input  logic [WIDTH-1:0] cpu_out
);

   localparam int RST_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int STAB_W = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RST  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  cpu_in_q, cpu_in_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic [WIDTH-1:0]  prev_out_q, prev_out_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;
   logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
   logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
   logic [STAB_W-1:0] stab_inc_s;
   logic              stable_s;
   logic              settled_s;
`ifdef HOST_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0]  run_cnt_q, run_cnt_d;
   logic [TMO_W-1:0]  run_inc_s;

   assign run_inc_s = run_cnt_q + TMO_W'(1);
`endif

   // prev_out is cleared outside RUN, so the first RUN sample never counts as stable.
   assign stable_s   = (cpu_out != {WIDTH{1'b0}}) && (cpu_out == prev_out_q);
   assign stab_inc_s = stab_cnt_q + STAB_W'(1);
   assign settled_s  = stable_s && (stab_inc_s == STAB_W'(SETTLE_CYCLES));

   // Next-state and next-output logic for the job sequencer.
   always_comb begin
      state_d     = state_q;
      cpu_in_d    = cpu_in_q;
      result_d    = result_q;
      cpu_reset_d = cpu_reset_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
      rst_cnt_d   = rst_cnt_q;
      stab_cnt_d  = {STAB_W{1'b0}};
      prev_out_d  = {WIDTH{1'b0}};
`ifdef HOST_TIMEOUT_EN
      run_cnt_d   = {TMO_W{1'b0}};
`endif
      case (state_q)
         S_IDLE: begin
            cpu_reset_d = 1'b1;
            busy_d      = 1'b0;
            if (start) begin
               cpu_in_d  = operand;
               rst_cnt_d = RST_W'(RESET_CYCLES - 1);
               busy_d    = 1'b1;
               state_d   = S_RST;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RST: begin
            cpu_reset_d = 1'b1;
            busy_d      = 1'b1;
            if (rst_cnt_q == {RST_W{1'b0}}) begin
               cpu_reset_d = 1'b0;
               state_d     = S_RUN;
            end else begin
               rst_cnt_d = rst_cnt_q - RST_W'(1);
            end
         end
         S_RUN: begin
            cpu_reset_d = 1'b0;
            busy_d      = 1'b1;
            prev_out_d  = cpu_out;
            if (stable_s) begin
               stab_cnt_d = stab_inc_s;
            end else begin
               stab_cnt_d = {STAB_W{1'b0}};
            end
`ifdef HOST_TIMEOUT_EN
            run_cnt_d = run_inc_s;
`endif
            if (settled_s) begin
               result_d    = cpu_out;
               cpu_reset_d = 1'b1;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               state_d     = S_DONE;
            end
`ifdef HOST_TIMEOUT_EN
            else if (run_inc_s == TMO_W'(TIMEOUT_CYCLES)) begin
               result_d    = {WIDTH{1'b0}};
               cpu_reset_d = 1'b1;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               timeout_d   = 1'b1;
               state_d     = S_DONE;
            end
`endif
            else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            cpu_reset_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
         end
         default: begin
            cpu_reset_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset parks the CPU in reset with everything cleared.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cpu_in_q    <= {WIDTH{1'b0}};
         result_q    <= {WIDTH{1'b0}};
         prev_out_q  <= {WIDTH{1'b0}};
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         rst_cnt_q   <= {RST_W{1'b0}};
         stab_cnt_q  <= {STAB_W{1'b0}};
`ifdef HOST_TIMEOUT_EN
         run_cnt_q   <= {TMO_W{1'b0}};
`endif
      end else begin
         state_q     <= state_d;
         cpu_in_q    <= cpu_in_d;
         result_q    <= result_d;
         prev_out_q  <= prev_out_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         rst_cnt_q   <= rst_cnt_d;
         stab_cnt_q  <= stab_cnt_d;
`ifdef HOST_TIMEOUT_EN
         run_cnt_q   <= run_cnt_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign timeout   = timeout_q;
   assign cpu_in    = cpu_in_q;
   assign cpu_reset = cpu_reset_q;

endmodule

// File: tb/tb_cpu_job_host.sv
// Randomized bench for cpu_job_host: a job-timeline model predicts every output each cycle,
// and a scripted CPU model answers on cpu_out once the host releases cpu_reset.
module tb_cpu_job_host;

   localparam int W      = 16;
   localparam int RC     = 2;
   localparam int SC     = 2;
   localparam int SEARCH = 4000;
`ifdef HOST_TIMEOUT_EN
   localparam int TMO    = 20;
   localparam bit TMO_EN = 1'b1;
`else
   localparam int TMO    = 65535;
   localparam bit TMO_EN = 1'b0;
`endif

   logic         CLK     = 1'b0;
   logic         reset   = 1'b0;
   logic         start   = 1'b0;
   logic [W-1:0] operand = '0;
   logic [W-1:0] cpu_out = '0;
   logic         busy, done, timeout, cpu_reset;
   logic [W-1:0] result, cpu_in;

   int checks   = 0;
   int failures = 0;

   // CPU output script: value appears on RUN cycle p_d, optional one-cycle glitch at p_gpos.
   int           p_d = 1, p_gpos = 0;
   logic [W-1:0] p_v = '0, p_g = '0;
   int           j_d = 1, j_gpos = 0;
   logic [W-1:0] j_v = '0, j_g = '0;
   int           cpu_r = 0;

   // Job-timeline model.
   bit           m_active = 1'b0;
   int           m_cyc = 0, m_run_len = 0, done_cyc = 0;
   logic [W-1:0] m_val = '0, m_result = '0, m_cpu_in = '0;
   bit           m_to = 1'b0;
   logic         e_busy, e_done, e_to, e_rst;

   cpu_job_host #(
      .WIDTH(W), .RESET_CYCLES(RC), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLK(CLK), .reset(reset), .start(start), .operand(operand),
      .busy(busy), .done(done), .result(result), .timeout(timeout),
      .cpu_in(cpu_in), .cpu_reset(cpu_reset), .cpu_out(cpu_out)
   );

   always #5 CLK = ~CLK;

   function automatic int gcd(input int a, input int b);
      int t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic int relprime(input int n);
      int m = 2;
      while (gcd(n, m) != 1) m++;
      return m;
   endfunction

   function automatic logic [W-1:0] prof_at(input int r, input int d, input logic [W-1:0] v,
                                            input int gpos, input logic [W-1:0] g);
      if (r <= 0) return '0;
      if (gpos != 0 && r == gpos) return g;
      if (r >= d) return v;
      return '0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Capture happens on the first RUN cycle whose last SC+1 samples are equal and nonzero.
   task automatic job_plan();
      bit ok;
      logic [W-1:0] cur;
      m_run_len = -1;
      for (int r = 1; r <= SEARCH && m_run_len < 0; r++) begin
         cur = prof_at(r, j_d, j_v, j_gpos, j_g);
         ok  = (cur != '0);
         for (int k = 1; k <= SC; k++)
            if (prof_at(r - k, j_d, j_v, j_gpos, j_g) != cur) ok = 1'b0;
         if (ok) begin
            m_run_len = r; m_val = cur; m_to = 1'b0;
         end else if (TMO_EN && r == TMO) begin
            m_run_len = r; m_val = '0; m_to = 1'b1;
         end
      end
      if (m_run_len < 0) begin
         m_run_len = 1 << 30; m_val = '0; m_to = 1'b0;
      end
   endtask

   // Model update on each edge, then the per-cycle output comparison.
   always @(posedge CLK) begin
      if (!reset) begin
         m_active = 1'b0; m_result = '0; m_cpu_in = '0;
      end else if (m_active) begin
         m_cyc++;
         if (m_cyc == RC + m_run_len + 1) m_result = m_val;
         else if (m_cyc > RC + m_run_len + 1) m_active = 1'b0;
      end else if (start) begin
         m_active = 1'b1; m_cyc = 1; m_cpu_in = operand;
         j_d = p_d; j_v = p_v; j_gpos = p_gpos; j_g = p_g;
         job_plan();
      end
      #1;
      done_cyc = RC + m_run_len + 1;
      e_busy = m_active && (m_cyc < done_cyc);
      e_done = m_active && (m_cyc == done_cyc);
      e_to   = e_done && m_to;
      e_rst  = !(m_active && m_cyc > RC && m_cyc < done_cyc);
      check("busy",      32'(busy),      32'(e_busy));
      check("done",      32'(done),      32'(e_done));
      check("timeout",   32'(timeout),   32'(e_to));
      check("cpu_reset", 32'(cpu_reset), 32'(e_rst));
      check("cpu_in",    32'(cpu_in),    32'(m_cpu_in));
      check("result",    32'(result),    32'(m_result));
   end

   // Scripted CPU: counts RUN cycles since cpu_reset fell and plays the job's script.
   always @(posedge CLK) begin
      #2;
      if (cpu_reset) begin
         cpu_r   = 0;
         cpu_out = '0;
      end else begin
         cpu_r++;
         cpu_out = prof_at(cpu_r, j_d, j_v, j_gpos, j_g);
      end
   end

   task automatic run_job(input logic [W-1:0] op, input logic [W-1:0] v, input int d,
                          input int gpos, input logic [W-1:0] g, input bit noise);
      int n = 0;
      p_v = v; p_d = d; p_gpos = gpos; p_g = g;
      operand = op;
      start   = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      while (m_active && n < 400) begin
         if (noise && $urandom_range(0, 3) == 0) begin
            start   = 1'b1;
            operand = 16'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge CLK);
         n++;
      end
      start = 1'b0;
      if (m_active) begin
         checks++; failures++;
         $display("FAIL job_budget actual=still_busy required=idle within 400 cycles");
      end
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge CLK);
         n++;
      end
      if (done !== 1'b1) begin
         checks++; failures++;
         $display("FAIL wait_done actual=no_done required=done within %0d cycles", budget);
      end
   endtask

   task automatic async_reset_test();
      int dn = 0;
      #2 reset = 1'b0;
      #1;
      check("async_busy",      32'(busy),      32'd0);
      check("async_done",      32'(done),      32'd0);
      check("async_result",    32'(result),    32'd0);
      check("async_cpu_reset", 32'(cpu_reset), 32'd1);
      check("async_cpu_in",    32'(cpu_in),    32'd0);
      check("async_timeout",   32'(timeout),   32'd0);
      @(negedge CLK);
      @(negedge CLK);
      reset = 1'b1;
      repeat (20) begin
         @(negedge CLK);
         if (done) dn++;
      end
      check("no_done_after_reset", 32'(dn), 32'd0);
   endtask

   initial begin
      int n;
      int d, gp;
      logic [W-1:0] op;

      repeat (3) @(negedge CLK);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_done",      32'(done),      32'd0);
      check("rst_result",    32'(result),    32'd0);
      check("rst_cpu_in",    32'(cpu_in),    32'd0);
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_timeout",   32'(timeout),   32'd0);
      check("model_relprime_5040",  32'(relprime(5040)),  32'd11);
      check("model_relprime_30030", 32'(relprime(30030)), 32'd17);
      reset = 1'b1;
      @(negedge CLK);

      run_job(16'h13B0, 16'(relprime(5040)), 6, 0, 16'd0, 1'b0);
      check("job_5040_result", 32'(result), 32'd11);

      // Back-to-back: start is raised in the done cycle and held into the next one.
      p_v = 16'(relprime(30030)); p_d = 7; p_gpos = 0; p_g = '0;
      operand = 16'd30030;
      start   = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      wait_done(200, n);
      check("job_30030_result", 32'(result), 32'd17);
      p_v = 16'd11; p_d = 3;
      operand = 16'h13B0;
      start   = 1'b1;
      @(negedge CLK);
      check("done_one_cycle", 32'(done), 32'd0);
      @(negedge CLK);
      start = 1'b0;
      wait_done(200, n);
      check("b2b_result", 32'(result), 32'd11);
      check("b2b_busy_in_done", 32'(busy), 32'd0);
      @(negedge CLK);

      run_job(16'h0042, 16'd7, 4, 2, 16'd5, 1'b1);
      check("glitch_result", 32'(result), 32'd7);

      for (int i = 0; i < 40; i++) begin
         op = 16'($urandom_range(1, 65535));
         d  = $urandom_range(1, 12);
         gp = ($urandom_range(0, 1) == 1) ? $urandom_range(1, d + 2) : 0;
         run_job(op, 16'(relprime(int'(op))), d, gp, 16'($urandom_range(1, 65535)),
                 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) @(negedge CLK);
      end

`ifdef HOST_TIMEOUT_EN
      p_v = '0; p_d = 1; p_gpos = 0;
      operand = 16'h1234;
      start   = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      wait_done(100, n);
      check("timeout_pulse",  32'(timeout), 32'd1);
      check("timeout_result", 32'(result),  32'd0);
      check("timeout_cycles", 32'(n),       32'd22);
      @(negedge CLK);
      run_job(16'h13B0, 16'd11, 2, 0, 16'd0, 1'b0);
      check("post_timeout_result", 32'(result), 32'd11);
      p_v = 16'd9; p_d = 40;
      operand = 16'h0BAD;
      start   = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (RC + 10) @(negedge CLK);
`else
      p_v = '0; p_d = 1; p_gpos = 0;
      operand = 16'h1234;
      start   = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (1000) @(negedge CLK);
      check("stuck_busy", 32'(busy), 32'd1);
`endif
      async_reset_test();

      run_job(16'h13B0, 16'd11, 5, 0, 16'd0, 1'b0);
      check("post_reset_result", 32'(result), 32'd11);
      repeat (3) @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_job_host.md
Name: cpu_job_host

Overview:
- Host-side sequencer for the 16-bit multicycle CPU's inputWire/outputWire interface; it drives that interface from the other end.
- Accepts one operand per job via a start/busy/done handshake.
- For each job it holds the CPU in reset, presents the operand, releases reset, then waits until the CPU output is nonzero and stable.
- It captures that value as the job result; used by FPGA top level and system benches in place of hand-sequenced reset/input stimulus.

Parameters:
- WIDTH, 16, data width of operand, result, cpu_in, cpu_out.
- RESET_CYCLES, 2, cycles cpu_reset is held high per job (min 1).
- SETTLE_CYCLES, 2, consecutive cycles cpu_out must be nonzero and unchanged before capture (min 1).
- TIMEOUT_CYCLES, 65535, max RUN cycles before the job aborts (only with HOST_TIMEOUT_EN).

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset for this block (0 = reset).
- start  input  1  job request; sampled only in IDLE.
- operand  input  WIDTH  job operand; captured on the accepted start.
- busy  output  1  high from the cycle after start is accepted until DONE is entered.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  captured CPU output; holds until the next capture.
- timeout  output  1  one-cycle pulse coincident with done on an aborted job.
- cpu_in  output  WIDTH  to CPU inputWire.
- cpu_reset  output  1  to CPU reset, active-high.
- cpu_out  input  WIDTH  from CPU outputWire.

Behaviour:
- Reset values (reset=0): state IDLE, busy 0, done 0, timeout 0, result 0, cpu_in 0, cpu_reset 1 (CPU held in reset while host is in reset), all counters 0.
- IDLE: cpu_reset=1.
  - start=1 -> latch operand into cpu_in, load reset counter, go RST.
  - start during any other state is ignored (no queueing).
- RST: cpu_reset=1, cpu_in stable.
  - Counter counts RESET_CYCLES cycles, then go RUN.
  - On the RUN-entry edge cpu_reset goes 0.
- RUN: cpu_reset=0.
  - Stability counter resets when cpu_out==0 or cpu_out differs from its previous-cycle registered copy; otherwise it increments.
  - When it reaches SETTLE_CYCLES with cpu_out!=0 -> result<=cpu_out, go DONE.
  - Transient nonzero glitches shorter than SETTLE_CYCLES are never captured.
- DONE: single cycle.
  - done=1, busy=0, cpu_reset returns to 1, then IDLE.
  - A start in the DONE cycle is ignored; earliest new acceptance is the next cycle.
- Latency: start accepted at edge N -> first CPU-run cycle N+RESET_CYCLES+1; done = CPU compute time + SETTLE_CYCLES + 1 after output first goes nonzero.
- cpu_in changes only on an accepted start; it holds the last operand in IDLE.
- Async reset mid-job: immediate return to reset values. A partially run job produces no done; result is cleared to 0.
- Result of 0 cannot be reported; the CPU protocol signals completion with a nonzero output.

Optional Feature:
- Macro: HOST_TIMEOUT_EN.
- Defined:
  - RUN-cycle counter of width ceil(log2(TIMEOUT_CYCLES+1)).
  - When it reaches TIMEOUT_CYCLES without capture -> result<=0, go DONE with timeout=1 pulsed alongside done.
  - Capture and timeout in the same cycle: capture wins, timeout=0.
- Not defined: no counter; RUN waits indefinitely; timeout tied 0.

Test Plan:
- Reset behaviour: assert reset=0 mid-RUN -> busy=0, done=0, result=0, cpu_reset=1 immediately (asynchronously); no done pulse after release.
- Single job with behavioural relPrime CPU model: operand=0x13B0 (5040), start 1 cycle -> cpu_reset high exactly 2 cycles, then low; result=11; done single cycle; busy low in the done cycle.
- Back-to-back jobs:
  - Job 1 operand=30030 -> result=17.
  - Start asserted the cycle after done with operand=0x13B0 -> accepted, cpu_reset re-asserted 2 cycles, result=11.
- Glitch filter:
  - Model drives cpu_out=5 for 1 cycle, then 0, then 7 steady -> result=7 captured after 2 stable cycles.
  - start pulses during RUN are ignored.
- With HOST_TIMEOUT_EN, TIMEOUT_CYCLES=20: model keeps cpu_out=0 -> done and timeout pulse on RUN cycle 20, result=0; without macro, busy stays high for 1000 cycles.
